// File: rtl/arm_encoder.sv
// ARM instruction encoder: takes decoded data-processing or multiply fields
// over a valid/ready handshake and assembles the 32-bit instruction word.
// Immediate constants are folded into rotated-imm8 form by a search that
// tries one rotation per cycle. Each word is tagged with a byte address.
module arm_encoder #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              kind,
  input  logic [3:0]        cond,
  input  logic [3:0]        opcode,
  input  logic              s_bit,
  input  logic [3:0]        rn,
  input  logic [3:0]        rd,
  input  logic [3:0]        rm,
  input  logic [3:0]        rs,
  input  logic [1:0]        op2_mode,
  input  logic [31:0]       imm_value,
  input  logic [1:0]        shift_type,
  input  logic [4:0]        shift_amt,
  input  logic [2:0]        mul_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    IMM_SEARCH = 2'd1,
    EMIT       = 2'd2
  } state_t;

  state_t state, state_next;

  // Captured request fields
  logic              kind_reg;
  logic [3:0]        cond_reg;
  logic [3:0]        opcode_reg;
  logic              s_bit_reg;
  logic [3:0]        rn_reg;
  logic [3:0]        rd_reg;
  logic [3:0]        rm_reg;
  logic [3:0]        rs_reg;
  logic [1:0]        op2_mode_reg;
  logic [31:0]       imm_value_reg;
  logic [1:0]        shift_type_reg;
  logic [4:0]        shift_amt_reg;
  logic [2:0]        mul_op_reg;

  // Search / result state
  logic [3:0]        r_reg;
  logic [3:0]        rot_reg;
  logic [7:0]        imm8_reg;
  logic              err_reg;
  logic [ADDR_W-1:0] addr_reg;

  logic [31:0]       cand;
  logic              cand_fits;
  logic              req_bad;
  logic              accept;
  logic              mul_ok;

  logic              is_compare;
  logic              is_move;
  logic              s_eff;
  logic [3:0]        rd_eff;
  logic [3:0]        rn_eff;
  logic [11:0]       op2;
  logic [31:0]       word_dp;
  logic [31:0]       word_mul;

  assign accept   = (state == IDLE) && req_valid;
  assign out_addr = addr_reg;

  // Candidate for the current rotation: imm rotated left by 2*r. A shift by 32
  // yields zero, which makes r=0 fall out of the same expression.
  always_comb begin
    cand      = (imm_value_reg << {r_reg, 1'b0})
              | (imm_value_reg >> (6'd32 - {1'b0, r_reg, 1'b0}));
    cand_fits = (cand[31:8] == 24'd0);
  end

  // Requests that can be rejected straight away, judged on the live inputs
  always_comb begin
    case (mul_op)
      3'b000, 3'b001, 3'b100, 3'b110: mul_ok = 1'b1;
      default:                        mul_ok = 1'b0;
    endcase
    req_bad = kind ? !mul_ok : (op2_mode == 2'd3);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (req_valid) state_next = (!kind && op2_mode == 2'd0) ? IMM_SEARCH : EMIT;
      IMM_SEARCH: if (cand_fits || r_reg == 4'd15) state_next = EMIT;
      EMIT:       if (out_ready) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Request capture, rotation search and address counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_reg       <= 1'b0;
      cond_reg       <= 4'd0;
      opcode_reg     <= 4'd0;
      s_bit_reg      <= 1'b0;
      rn_reg         <= 4'd0;
      rd_reg         <= 4'd0;
      rm_reg         <= 4'd0;
      rs_reg         <= 4'd0;
      op2_mode_reg   <= 2'd0;
      imm_value_reg  <= 32'd0;
      shift_type_reg <= 2'd0;
      shift_amt_reg  <= 5'd0;
      mul_op_reg     <= 3'd0;
      r_reg          <= 4'd0;
      rot_reg        <= 4'd0;
      imm8_reg       <= 8'd0;
      err_reg        <= 1'b0;
      addr_reg       <= ADDR_W'(BASE_ADDR);
    end else begin
      if (accept) begin
        kind_reg       <= kind;
        cond_reg       <= cond;
        opcode_reg     <= opcode;
        s_bit_reg      <= s_bit;
        rn_reg         <= rn;
        rd_reg         <= rd;
        rm_reg         <= rm;
        rs_reg         <= rs;
        op2_mode_reg   <= op2_mode;
        imm_value_reg  <= imm_value;
        shift_type_reg <= shift_type;
        shift_amt_reg  <= shift_amt;
        mul_op_reg     <= mul_op;
        r_reg          <= 4'd0;
        err_reg        <= req_bad;
      end
      if (state == IMM_SEARCH) begin
        // First fitting rotation wins because the state leaves on that cycle
        if (cand_fits) begin
          imm8_reg <= cand[7:0];
          rot_reg  <= r_reg;
        end else if (r_reg == 4'd15) begin
          err_reg <= 1'b1;
        end
        r_reg <= r_reg + 4'd1;
      end
      // Erroneous words consume no address
      if (state == EMIT && out_ready && !err_reg) begin
        addr_reg <= addr_reg + ADDR_W'(4);
      end
    end
  end

  // Assemble both instruction formats from the captured fields
  always_comb begin
    is_compare = (opcode_reg[3:2] == 2'b10);
    is_move    = (opcode_reg == 4'hD) || (opcode_reg == 4'hF);
    s_eff      = s_bit_reg | is_compare;
    rd_eff     = is_compare ? 4'd0 : rd_reg;
    rn_eff     = is_move ? 4'd0 : rn_reg;
    case (op2_mode_reg)
      2'd0:    op2 = {rot_reg, imm8_reg};
      2'd1:    op2 = {shift_amt_reg, shift_type_reg, 1'b0, rm_reg};
      2'd2:    op2 = {rs_reg, 1'b0, shift_type_reg, 1'b1, rm_reg};
      default: op2 = 12'd0;
    endcase
    word_dp  = {cond_reg, 2'b00, (op2_mode_reg == 2'd0), opcode_reg, s_eff,
                rn_eff, rd_eff, op2};
    word_mul = {cond_reg, 4'b0000, mul_op_reg, s_bit_reg, rd_reg, rn_reg,
                rs_reg, 4'b1001, rm_reg};
  end

  // Handshake and result outputs; instr reads zero outside EMIT and on error
  always_comb begin
    req_ready = (state == IDLE);
    out_valid = (state == EMIT);
    out_err   = (state == EMIT) && err_reg;
    instr     = 32'd0;
    if (state == EMIT && !err_reg) begin
      instr = kind_reg ? word_mul : word_dp;
    end
  end

endmodule

// File: tb/tb_arm_encoder.sv
// Bench for arm_encoder: directed cases plus randomized requests, checked by a
// scoreboard fed from a behavioural model and drained by an output monitor.
module tb_arm_encoder;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              kind = 1'b0;
  logic [3:0]        cond = 4'd0;
  logic [3:0]        opcode = 4'd0;
  logic              s_bit = 1'b0;
  logic [3:0]        rn = 4'd0;
  logic [3:0]        rd = 4'd0;
  logic [3:0]        rm = 4'd0;
  logic [3:0]        rs = 4'd0;
  logic [1:0]        op2_mode = 2'd0;
  logic [31:0]       imm_value = 32'd0;
  logic [1:0]        shift_type = 2'd0;
  logic [4:0]        shift_amt = 5'd0;
  logic [2:0]        mul_op = 3'd0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  arm_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(32'd0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .kind(kind), .cond(cond), .opcode(opcode), .s_bit(s_bit),
    .rn(rn), .rd(rd), .rm(rm), .rs(rs), .op2_mode(op2_mode),
    .imm_value(imm_value), .shift_type(shift_type), .shift_amt(shift_amt),
    .mul_op(mul_op), .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .out_addr(out_addr), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        kind;
    logic [3:0]  cond, opcode, rn, rd, rm, rs;
    logic        s;
    logic [1:0]  mode, st;
    logic [31:0] imm;
    logic [4:0]  sa;
    logic [2:0]  mul_op;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [7:0]  addr;
    int          lat;
    int          start;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
  logic [7:0]  model_addr = 8'd0;
  logic [31:0] last_instr = 32'd0;
  logic        last_err = 1'b0;
  logic [7:0]  last_addr = 8'd0;
  int          last_lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Reference model: builds the word from the field rules directly
  function automatic exp_t model(req_t q);
    exp_t        e;
    logic [31:0] op2, cand, s, rdv, rnv;
    bit          found, cmp, mov;
    int          rot, k;
    e.err = 0; e.lat = 1; e.instr = 0; e.addr = 0; e.start = 0;
    op2 = 0; found = 0; rot = 0;
    if (q.kind) begin
      if (!(q.mul_op == 0 || q.mul_op == 1 || q.mul_op == 4 || q.mul_op == 6))
        e.err = 1;
      else
        e.instr = 32'(q.cond) * 32'h1000_0000 + 32'(q.mul_op) * 32'h20_0000
                + 32'(q.s) * 32'h10_0000 + 32'(q.rd) * 32'h1_0000
                + 32'(q.rn) * 32'h1000 + 32'(q.rs) * 32'h100 + 32'h90 + 32'(q.rm);
    end else begin
      case (q.mode)
        2'd0: begin
          for (int r = 0; r < 16; r++) begin
            k = 2 * r;
            cand = (k == 0) ? q.imm : ((q.imm << k) | (q.imm >> (32 - k)));
            if (!found && cand < 256) begin
              found = 1; rot = r; op2 = 32'(r) * 256 + cand;
            end
          end
          if (found) e.lat = rot + 2;
          else begin e.err = 1; e.lat = 17; end
        end
        2'd1: op2 = 32'(q.sa) * 128 + 32'(q.st) * 32 + 32'(q.rm);
        2'd2: op2 = 32'(q.rs) * 256 + 32'(q.st) * 32 + 16 + 32'(q.rm);
        default: e.err = 1;
      endcase
      cmp = (q.opcode >= 8 && q.opcode <= 11);
      mov = (q.opcode == 13 || q.opcode == 15);
      s   = (q.s || cmp) ? 1 : 0;
      rdv = cmp ? 0 : 32'(q.rd);
      rnv = mov ? 0 : 32'(q.rn);
      if (!e.err)
        e.instr = 32'(q.cond) * 32'h1000_0000 + ((q.mode == 0) ? 32'h200_0000 : 0)
                + 32'(q.opcode) * 32'h20_0000 + s * 32'h10_0000
                + rnv * 32'h1_0000 + rdv * 32'h1000 + op2;
    end
    return e;
  endfunction

  function automatic req_t blank();
    req_t q;
    q.kind = 0; q.cond = 4'hE; q.opcode = 0; q.rn = 0; q.rd = 0; q.rm = 0;
    q.rs = 0; q.s = 0; q.mode = 0; q.st = 0; q.imm = 0; q.sa = 0; q.mul_op = 0;
    return q;
  endfunction

  task automatic issue(input req_t q);
    exp_t e;
    int   t;
    @(negedge clk);
    kind = q.kind; cond = q.cond; opcode = q.opcode; s_bit = q.s;
    rn = q.rn; rd = q.rd; rm = q.rm; rs = q.rs; op2_mode = q.mode;
    imm_value = q.imm; shift_type = q.st; shift_amt = q.sa; mul_op = q.mul_op;
    req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 100) begin @(negedge clk); t++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready=%0b required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    e = model(q);
    e.addr = model_addr;
    e.start = cyc;
    if (!e.err) model_addr = model_addr + 8'd4;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    // Fields are captured at accept; scrambling them now must not matter
    cond = 4'($urandom); rn = 4'($urandom); rd = 4'($urandom);
    imm_value = $urandom; mul_op = 3'($urandom); op2_mode = 2'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin @(negedge clk); t++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d outstanding required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    model_addr = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Output ready driver, changes just after the rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: checks latency on first sight of a word, contents on handshake
  initial begin
    exp_t e;
    bit   seen;
    seen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) seen = 0;
      else if (out_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: instr=0x%08h with empty scoreboard", instr);
        end else begin
          if (!seen) begin
            seen = 1;
            last_lat = cyc - sb[0].start;
            check("latency", 32'(last_lat), 32'(sb[0].lat));
          end
          if (out_ready) begin
            e = sb.pop_front();
            seen = 0;
            check("instr", instr, e.instr);
            check("out_err", 32'(out_err), 32'(e.err));
            check("out_addr", 32'(out_addr), 32'(e.addr));
            last_instr = instr; last_err = out_err; last_addr = out_addr;
            $display("txn addr=0x%02h instr=0x%08h err=%0b lat=%0d",
                     out_addr, instr, out_err, last_lat);
          end
        end
      end
    end
  end

  initial begin
    req_t q;
    int   t;
    logic [2:0]  mops [6];
    logic [31:0] base;
    int          k;
    mops = '{3'd0, 3'd1, 3'd4, 3'd6, 3'd5, 3'd7};

    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    rst_n = 1'b1;

    // ADD r1, r2, #0xFF
    q = blank(); q.opcode = 4'h4; q.rn = 2; q.rd = 1; q.imm = 32'hFF;
    issue(q); drain();
    check("t1_instr", last_instr, 32'hE28210FF);
    check("t1_lat", 32'(last_lat), 32'd2);
    check("t1_addr", 32'(last_addr), 32'd0);
    check("t1_addr_after", 32'(out_addr), 32'd4);

    // MOV r3, #0xFF000000 with Rn forced to zero
    q = blank(); q.opcode = 4'hD; q.rd = 3; q.rn = 7; q.imm = 32'hFF000000;
    issue(q); drain();
    check("t2_instr", last_instr, 32'hE3A034FF);
    check("t2_lat", 32'(last_lat), 32'd6);

    // Unencodable constant, then an illegal operand mode
    q = blank(); q.opcode = 4'h4; q.imm = 32'h101;
    issue(q); drain();
    check("t3_err", 32'(last_err), 32'd1);
    check("t3_instr", last_instr, 32'd0);
    check("t3_lat", 32'(last_lat), 32'd17);
    check("t3_addr_hold", 32'(out_addr), 32'd8);
    q = blank(); q.mode = 2'd3;
    issue(q); drain();
    check("t3_mode3_err", 32'(last_err), 32'd1);
    check("t3_mode3_lat", 32'(last_lat), 32'd1);

    // SUBS r4, r5, r6 LSL #3 then CMP r1, r2 (S and Rd forced)
    do_reset();
    q = blank(); q.opcode = 4'h2; q.s = 1; q.rn = 5; q.rd = 4; q.rm = 6;
    q.mode = 2'd1; q.sa = 5'd3;
    issue(q); drain();
    check("t4_sub", last_instr, 32'hE0554186);
    check("t4_sub_addr", 32'(last_addr), 32'd0);
    q = blank(); q.opcode = 4'hA; q.rn = 1; q.rd = 9; q.rm = 2; q.mode = 2'd1;
    issue(q); drain();
    check("t4_cmp", last_instr, 32'hE1510002);
    check("t4_cmp_addr", 32'(last_addr), 32'd4);

    // MUL r0, r1, r2 with the consumer stalled
    ready_mode = 2;
    q = blank(); q.kind = 1; q.rm = 1; q.rs = 2;
    issue(q);
    t = 0;
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    for (int i = 0; i < 3; i++) begin
      check("t5_stall_instr", instr, 32'hE0000291);
      check("t5_stall_ready", 32'(req_ready), 32'd0);
      check("t5_stall_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    ready_mode = 0;
    drain();
    q = blank(); q.kind = 1; q.mul_op = 3'b101;
    issue(q); drain();
    check("t5_mul101_err", 32'(last_err), 32'd1);

    // Reset in the middle of a rotation search
    q = blank(); q.opcode = 4'h4; q.imm = 32'h101;
    issue(q);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_ready", 32'(req_ready), 32'd1);
    check("t6_rst_addr", 32'(out_addr), 32'd0);
    sb.delete();
    model_addr = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;

    // 64 successful words walk the address through 0xFC back to 0x00
    for (int i = 0; i < 64; i++) begin
      q = blank(); q.opcode = 4'hD; q.rd = 4'(i); q.rm = 4'(i + 1); q.mode = 2'd1;
      issue(q);
    end
    drain();
    check("t6_wrap_last", 32'(last_addr), 32'hFC);
    check("t6_wrap_addr", 32'(out_addr), 32'd0);

    // Randomized traffic with random back-pressure
    ready_mode = 1;
    for (int i = 0; i < 150; i++) begin
      q.kind = ($urandom_range(0, 3) == 0);
      q.cond = 4'($urandom); q.opcode = 4'($urandom); q.s = 1'($urandom);
      q.rn = 4'($urandom); q.rd = 4'($urandom); q.rm = 4'($urandom);
      q.rs = 4'($urandom); q.mode = 2'($urandom); q.st = 2'($urandom);
      q.sa = 5'($urandom); q.mul_op = mops[$urandom_range(0, 5)];
      case ($urandom_range(0, 2))
        0: begin
          base = 32'($urandom_range(0, 255));
          k = 2 * $urandom_range(0, 15);
          q.imm = (k == 0) ? base : ((base >> k) | (base << (32 - k)));
        end
        1: q.imm = $urandom;
        default: q.imm = 32'($urandom_range(0, 1023));
      endcase
      issue(q);
    end
    drain();
    ready_mode = 0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
